// File: rtl/key_text_ctrl_if.sv
// Byte-receiver, ASCII-ROM and text-RAM write signals of the keyboard text sequencer.
// master = sequencer side, slave = receiver/ROM/RAM side.
interface key_text_ctrl_if #(parameter int AW = 12);
  logic          ps2_ready;
  logic [7:0]    ps2_data;
  logic          ps2_next;
  logic [7:0]    rom_addr;
  logic [7:0]    rom_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  modport master (input  ps2_ready, ps2_data, rom_data,
                  output ps2_next, rom_addr, wr_en, wr_addr, wr_data);
  modport slave  (output ps2_ready, ps2_data, rom_data,
                  input  ps2_next, rom_addr, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/key_text_ctrl.sv
// key_text_ctrl: PS/2 scancode -> text-RAM sequencer with shift/caps and cursor.
// Optional macro KEY_TYPEMATIC_EN: auto-repeated make codes each produce a write;
// without it, a make equal to the last held key is dropped until its break arrives.
module key_text_ctrl #(
  parameter int COLS        = 70,
  parameter int ROWS        = 30,
  parameter int LINE_STRIDE = 128,
  parameter int AW          = 12
) (
  input  logic            clk,
  input  logic            clrn,
  key_text_ctrl_if.master bus,
  output logic [6:0]      cur_col,
  output logic [4:0]      cur_row,
  output logic            busy
);
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_LOOKUP, S_WAIT, S_WRITE} state_t;

  localparam logic [7:0]    K_BRK   = 8'hF0;
  localparam logic [7:0]    K_EXT   = 8'hE0;
  localparam logic [7:0]    K_LSH   = 8'h12;
  localparam logic [7:0]    K_RSH   = 8'h59;
  localparam logic [7:0]    K_CAPS  = 8'h58;
  localparam logic [7:0]    K_ENTER = 8'h5A;
  localparam logic [7:0]    K_BKSP  = 8'h66;
  localparam logic [6:0]    LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]    LAST_ROW = 5'(ROWS - 1);
  localparam logic [AW-1:0] STRIDE_A = AW'(LINE_STRIDE);

  generate
    if (COLS > LINE_STRIDE || ROWS * LINE_STRIDE > (1 << AW)) begin : g_cfg_err
      $error("key_text_ctrl: text geometry does not fit in AW address bits");
    end
  endgenerate

  state_t          state_q, state_d;
  logic [7:0]      code_q, code_d, held_q, held_d, rom_addr_q, rom_addr_d;
  logic [7:0]      wr_data_q, wr_data_d, ch;
  logic            shift_q, shift_d, caps_q, caps_d, brk_q, brk_d, ext_q, ext_d;
  logic            ps2_next_q, ps2_next_d, wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [6:0]      col_q, col_d;
  logic [4:0]      row_q, row_d, row_inc;
  logic            is_shift, repeat_key, make_ok, is_ctl;

  function automatic logic [AW-1:0] addr_of(input logic [6:0] c, input logic [4:0] r);
    addr_of = AW'(r) * STRIDE_A + AW'(c);
  endfunction

  // Key classification of the byte under decode
  always_comb begin
    is_shift = (code_q == K_LSH) || (code_q == K_RSH);
`ifdef KEY_TYPEMATIC_EN
    repeat_key = 1'b0;
`else
    repeat_key = (code_q == held_q);
`endif
    make_ok = !brk_q && !ext_q && (code_q != K_BRK) && (code_q != K_EXT) && !repeat_key;
    is_ctl  = (code_q == K_ENTER) || (code_q == K_BKSP);
    row_inc = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
  end

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.ps2_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (make_ok && is_ctl)                                   state_d = S_WRITE;
        else if (make_ok && !is_shift && code_q != K_CAPS)       state_d = S_LOOKUP;
        else                                                     state_d = S_IDLE;
      end
      S_LOOKUP: state_d = S_WAIT;
      S_WAIT:   state_d = (bus.rom_data == 8'h00) ? S_IDLE : S_WRITE;
      S_WRITE:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath / output next values; outputs are registered so the write strobe
  // is high exactly while the FSM sits in WRITE
  always_comb begin
    code_d     = code_q;     held_d    = held_q;    rom_addr_d = rom_addr_q;
    shift_d    = shift_q;    caps_d    = caps_q;    brk_d      = brk_q;
    ext_d      = ext_q;      col_d     = col_q;     row_d      = row_q;
    wr_addr_d  = wr_addr_q;  wr_data_d = wr_data_q;
    ps2_next_d = 1'b0;       wr_en_d   = 1'b0;      ch         = bus.rom_data;
    unique case (state_q)
      S_IDLE: if (bus.ps2_ready) begin
        code_d     = bus.ps2_data;
        ps2_next_d = 1'b1;
      end
      S_DECODE: begin
        if (code_q == K_BRK)      brk_d = 1'b1;
        else if (code_q == K_EXT) ext_d = 1'b1;
        else if (brk_q) begin
          if (is_shift) shift_d = 1'b0;
`ifndef KEY_TYPEMATIC_EN
          if (code_q == held_q) held_d = 8'h00;
`endif
          brk_d = 1'b0;
          ext_d = 1'b0;
        end else if (ext_q) begin
          ext_d = 1'b0;
        end else if (!repeat_key) begin
`ifndef KEY_TYPEMATIC_EN
          held_d = code_q;
`endif
          if (is_shift)              shift_d = 1'b1;
          else if (code_q == K_CAPS) caps_d  = ~caps_q;
          else if (code_q == K_ENTER) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_of(col_q, row_q);
            wr_data_d = 8'h00;
            col_d     = 7'd0;
            row_d     = row_inc;
          end else if (code_q == K_BKSP) begin
            // cursor steps back first; at (0,0) it stays and address 0 is blanked
            if (col_q != 7'd0) col_d = col_q - 7'd1;
            else if (row_q != 5'd0) begin
              col_d = LAST_COL;
              row_d = row_q - 5'd1;
            end
            wr_en_d   = 1'b1;
            wr_addr_d = addr_of(col_d, row_d);
            wr_data_d = 8'h00;
          end else begin
            rom_addr_d = code_q;
          end
        end
      end
      S_WAIT: if (bus.rom_data != 8'h00) begin
        if (ch >= 8'h61 && ch <= 8'h7A && (shift_q ^ caps_q)) ch = ch - 8'h20;
        wr_en_d   = 1'b1;
        wr_addr_d = addr_of(col_q, row_q);
        wr_data_d = ch;
        if (col_q == LAST_COL) begin
          col_d = 7'd0;
          row_d = row_inc;
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      code_q <= '0; held_q <= '0; rom_addr_q <= '0; wr_data_q <= '0; wr_addr_q <= '0;
      shift_q <= 1'b0; caps_q <= 1'b0; brk_q <= 1'b0; ext_q <= 1'b0;
      ps2_next_q <= 1'b0; wr_en_q <= 1'b0; col_q <= '0; row_q <= '0;
    end else begin
      code_q <= code_d; held_q <= held_d; rom_addr_q <= rom_addr_d;
      wr_data_q <= wr_data_d; wr_addr_q <= wr_addr_d;
      shift_q <= shift_d; caps_q <= caps_d; brk_q <= brk_d; ext_q <= ext_d;
      ps2_next_q <= ps2_next_d; wr_en_q <= wr_en_d; col_q <= col_d; row_q <= row_d;
    end
  end

  assign bus.ps2_next = ps2_next_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign cur_col      = col_q;
  assign cur_row      = row_q;
  assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_key_text_ctrl.sv
// Directed bench for key_text_ctrl: FIFO + registered ROM model, write monitor.
module tb_key_text_ctrl;
  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [6:0] cur_col;
  logic [4:0] cur_row;
  logic       busy;

  key_text_ctrl_if #(.AW(12)) bus();

  key_text_ctrl #(.COLS(70), .ROWS(30), .LINE_STRIDE(128), .AW(12)) dut (
    .clk(clk), .clrn(clrn), .bus(bus),
    .cur_col(cur_col), .cur_row(cur_row), .busy(busy));

  always #5 clk = ~clk;

  logic [7:0] rom [256];
  logic [7:0] rom_q = 8'h00;
  always @(posedge clk) rom_q <= rom[bus.rom_addr];
  assign bus.rom_data = rom_q;

  int         checks = 0, errors = 0;
  int         wr_cnt = 0, nxt_cnt = 0, lat;
  logic [11:0] last_addr = '0;
  logic [7:0]  last_data = '0;
  bit          wr_now;
  logic [7:0]  fifo[$];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    bus.ps2_ready = (fifo.size() != 0);
    bus.ps2_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  // One clock: sample outputs on the falling edge, pop the FIFO on ps2_next
  task automatic tick();
    @(negedge clk);
    wr_now = bus.wr_en;
    if (bus.wr_en) begin
      wr_cnt++;
      last_addr = bus.wr_addr;
      last_data = bus.wr_data;
    end
    if (bus.ps2_next) begin
      nxt_cnt++;
      if (fifo.size() != 0) void'(fifo.pop_front());
    end
    drive();
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    drive();
  endtask

  task automatic tap(input logic [7:0] b);
    push(b); push(8'hF0); push(b);
  endtask

  task automatic settle();
    int n = 0;
    do begin tick(); n++; end while ((fifo.size() != 0 || busy) && n < 3000);
    if (n >= 3000) chk("settle_timeout", 1, 0);
    tick();
  endtask

  task automatic press_lat(input logic [7:0] b, output int l);
    push(b);
    l = 0;
    do begin tick(); l++; end while (!wr_now && l < 12);
  endtask

  task automatic pulse_reset();
    clrn = 1'b0; tick(); clrn = 1'b1; tick();
  endtask

  task automatic chk_wr(input string tag, input int n, input int a, input int d);
    chk({tag, "_cnt"}, wr_cnt, n);
    chk({tag, "_addr"}, last_addr, a);
    chk({tag, "_data"}, last_data, d);
    wr_cnt = 0;
  endtask

  task automatic chk_cur(input string tag, input int c, input int r);
    chk({tag, "_col"}, cur_col, c);
    chk({tag, "_row"}, cur_row, r);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h1C] = 8'h61;  // 'a'
    rom[8'h16] = 8'h31;  // '1'
    drive();
    tick(); tick();
    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_next", bus.ps2_next, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk_cur("rst", 0, 0);
    clrn = 1'b1; tick();

    // single key with break, latency and pop count
    nxt_cnt = 0; wr_cnt = 0;
    press_lat(8'h1C, lat);
    chk("lat_print", lat, 4);
    push(8'hF0); push(8'h1C); settle();
    chk_wr("key_a", 1, 12'h000, 8'h61);
    chk_cur("key_a", 1, 0);
    chk("next_pulses", nxt_cnt, 3);

    // reset asserted while waiting on the ROM
    push(8'h1C); tick(); tick(); tick();
    clrn = 1'b0; tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_rom", bus.rom_addr, 0);
    chk("midrst_wr_en", bus.wr_en, 0);
    chk_cur("midrst", 0, 0);
    clrn = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("midrst_nowrite", wr_cnt, 0);

    // shift, caps, shift+caps, shifted non-letter
    push(8'h12); tap(8'h1C); push(8'hF0); push(8'h12); settle();
    chk_wr("shift", 1, 12'h000, 8'h41);
    tap(8'h58); push(8'h1C); settle();
    chk_wr("caps", 1, 12'h001, 8'h41);
    push(8'h12); push(8'h1C); settle();
    chk_wr("shcaps", 1, 12'h002, 8'h61);
    push(8'hF0); push(8'h1C); push(8'hF0); push(8'h12); tap(8'h58); settle();
    chk("cleanup_nowrite", wr_cnt, 0);
    push(8'h12); tap(8'h16); push(8'hF0); push(8'h12); settle();
    chk_wr("digit", 1, 12'h003, 8'h31);
    chk_cur("digit", 4, 0);

    // Enter
    press_lat(8'h5A, lat);
    chk("lat_enter", lat, 2);
    push(8'hF0); push(8'h5A); settle();
    chk_wr("enter", 1, 12'h004, 8'h00);
    chk_cur("enter", 0, 1);

    // Backspace across line start, mid-line, and at origin
    tap(8'h66); settle();
    chk_wr("bs_wrap", 1, 12'h045, 8'h00);
    chk_cur("bs_wrap", 69, 0);
    tap(8'h66); settle();
    chk_wr("bs_mid", 1, 12'h044, 8'h00);
    chk_cur("bs_mid", 68, 0);
    pulse_reset();
    tap(8'h66); settle();
    chk_wr("bs_origin", 1, 12'h000, 8'h00);
    chk_cur("bs_origin", 0, 0);

    // full line then column wrap
    for (int i = 0; i < 70; i++) tap(8'h1C);
    settle();
    chk_wr("line", 70, 12'h045, 8'h61);
    chk_cur("line", 0, 1);
    tap(8'h1C); settle();
    chk_wr("line2", 1, 12'h080, 8'h61);
    chk_cur("line2", 1, 1);

    // unmapped key and extended make/break produce nothing
    tap(8'h15); push(8'hE0); push(8'h1C); push(8'hE0); push(8'hF0); push(8'h1C); settle();
    chk("silent_keys", wr_cnt, 0);
    chk_cur("silent", 1, 1);

    // Enter down to the last row, then wrap back to row 0
    for (int i = 0; i < 28; i++) tap(8'h5A);
    settle();
    chk_cur("row29", 0, 29);
    wr_cnt = 0;
    tap(8'h5A); settle();
    chk_wr("row_wrap", 1, 12'hE80, 8'h00);
    chk_cur("row_wrap", 0, 0);

    // held key with no break
    push(8'h1C); push(8'h1C); push(8'h1C); settle();
`ifdef KEY_TYPEMATIC_EN
    chk("repeat_cnt", wr_cnt, 3);
    chk_cur("repeat", 3, 0);
`else
    chk("repeat_cnt", wr_cnt, 1);
    chk_cur("repeat", 1, 0);
`endif
    push(8'hF0); push(8'h1C); settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
